// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and registered result/flags.
// One operation in flight. Logic, add/sub (with carry/borrow), shifts and MOV
// complete in one cycle. MUL/MULH/DIVU/REMU iterate WIDTH cycles.
// Ports:
//   clk, rst_n           - clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  - request handshake (ready only in IDLE)
//   op, a_in, b_in       - opcode and operands
//   carry_in             - carry for ADC, borrow for SBC
//   override, override_en- force result to override (latency 1)
//   out_valid / out_ready- result handshake (valid only in DONE)
//   result, V, C, N, Z, X, set_VC - registered result and flags
module alu_mc #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] override,
  input  logic             override_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             X,
  output logic             set_VC
);

  localparam int CW  = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef enum logic [3:0] {
    OP_NOT, OP_AND, OP_OR,  OP_XOR, OP_ADD, OP_SUB, OP_MOV, OP_ADC,
    OP_SBC, OP_SHL, OP_SHR, OP_ASR, OP_MUL, OP_MULH, OP_DIVU, OP_REMU
  } op_t;

  function automatic logic is_multi(input logic [3:0] o);
    return o[3:2] == 2'b11;
  endfunction

  function automatic logic sets_vc(input logic [3:0] o);
    return !((o[3:2] == 2'b00) || (o == OP_MOV));
  endfunction

  state_t state_q, state_d;

  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, x_q, x_d, svc_q, svc_d;

  // Single-cycle datapath, fed straight from the inputs on the accept cycle.
  logic [WIDTH-1:0] alu_res;
  logic             alu_v, alu_c;
  logic [WIDTH:0]   sum, sh_l, sh_r, cin_ext;
  logic [SHW-1:0]   amt;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    sum     = '0;
    sh_l    = '0;
    sh_r    = '0;
    cin_ext = {{WIDTH{1'b0}}, carry_in};
    amt     = b_in[SHW-1:0];
    case (op)
      OP_NOT: alu_res = ~a_in;
      OP_AND: alu_res = a_in & b_in;
      OP_OR:  alu_res = a_in | b_in;
      OP_XOR: alu_res = a_in ^ b_in;
      OP_MOV: alu_res = b_in;
      OP_ADD, OP_ADC: begin
        sum     = {1'b0, a_in} + {1'b0, b_in} + ((op == OP_ADC) ? cin_ext : '0);
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_in[MSB] == b_in[MSB]) & (a_in[MSB] ^ sum[MSB]);
      end
      OP_SUB, OP_SBC: begin
        sum     = {1'b0, a_in} - {1'b0, b_in} - ((op == OP_SBC) ? cin_ext : '0);
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_in[MSB] ^ b_in[MSB]) & (a_in[MSB] ^ sum[MSB]);
      end
      // Shifts run on a WIDTH+1 vector so the last bit shifted out lands in
      // the spare bit; a zero amount leaves that bit 0.
      OP_SHL: begin
        sh_l    = {1'b0, a_in} << amt;
        alu_res = sh_l[MSB:0];
        alu_c   = sh_l[WIDTH];
      end
      OP_SHR: begin
        sh_r    = {a_in, 1'b0} >> amt;
        alu_res = sh_r[WIDTH:1];
        alu_c   = sh_r[0];
      end
      OP_ASR: begin
        sh_r    = $signed({a_in, 1'b0}) >>> amt;
        alu_res = sh_r[WIDTH:1];
        alu_c   = sh_r[0];
      end
      default: alu_res = '0;
    endcase
  end

  // Iterative step. hi:lo is the shared working pair:
  //   multiply: hi accumulates, lo starts as the multiplier and shifts right.
  //   divide:   hi is the partial remainder, lo starts as the dividend and
  //             fills with quotient bits. A zero divisor naturally yields an
  //             all-ones quotient and a remainder equal to the dividend.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic             div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi   = mul_sum[WIDTH:1];
    mul_lo   = {mul_sum[0], lo_q[MSB:1]};
    div_sh   = {hi_q, lo_q[MSB]};
    div_ge   = div_sh >= {1'b0, b_q};
    div_diff = div_sh - {1'b0, b_q};
    div_hi   = div_ge ? div_diff[MSB:0] : div_sh[MSB:0];
    div_lo   = {lo_q[MSB-1:0], div_ge};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (override_en || !is_multi(op)) ? DONE : BUSY;
      BUSY: if (cnt_q == CW'(1)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath registers and result/flag write
  logic             wr;
  logic [WIDTH-1:0] res_new;
  logic             v_new, c_new, svc_new;

  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    wr       = 1'b0;
    res_new  = '0;
    v_new    = 1'b0;
    c_new    = 1'b0;
    svc_new  = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = op;
        a_d     = a_in;
        b_d     = b_in;
        svc_new = sets_vc(op);
        if (override_en) begin
          wr      = 1'b1;
          res_new = override;
        end else if (is_multi(op)) begin
          cnt_d = CW'(WIDTH);
          hi_d  = '0;
          lo_d  = op[1] ? a_in : b_in;
        end else begin
          wr      = 1'b1;
          res_new = alu_res;
          v_new   = alu_v;
          c_new   = alu_c;
        end
      end
      BUSY: begin
        cnt_d   = cnt_q - CW'(1);
        hi_d    = op_q[1] ? div_hi : mul_hi;
        lo_d    = op_q[1] ? div_lo : mul_lo;
        svc_new = sets_vc(op_q);
        if (cnt_q == CW'(1)) begin
          wr = 1'b1;
          case (op_q)
            OP_MUL:  begin res_new = mul_lo; c_new = (mul_hi != '0); end
            OP_MULH: res_new = mul_hi;
            OP_DIVU: begin res_new = div_lo; c_new = (b_q == '0); end
            default: begin res_new = div_hi; c_new = (b_q == '0); end
          endcase
        end
      end
      default: ;
    endcase

    result_d = result_q;
    v_d      = v_q;
    c_d      = c_q;
    n_d      = n_q;
    z_d      = z_q;
    x_d      = x_q;
    svc_d    = svc_q;
    if (wr) begin
      result_d = res_new;
      v_d      = v_new;
      c_d      = c_new;
      n_d      = res_new[MSB];
      z_d      = (res_new == '0);
      x_d      = (res_new == '1);
      svc_d    = svc_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      v_q      <= 1'b0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b1;
      x_q      <= 1'b0;
      svc_q    <= 1'b0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      v_q      <= v_d;
      c_q      <= c_d;
      n_q      <= n_d;
      z_q      <= z_d;
      x_q      <= x_d;
      svc_q    <= svc_d;
    end
  end

  assign result = result_q;
  assign V      = v_q;
  assign C      = c_q;
  assign N      = n_q;
  assign Z      = z_q;
  assign X      = x_q;
  assign set_VC = svc_q;

endmodule
